// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - separable input-first switch allocator
// Stage 1 picks one VC per input, stage 2 picks one input per output; results are registered.
module switch_allocator #(
  parameter int PORT_NUM = 5,
  parameter int VC_NUM = 2,
  localparam int PORT_SIZE = $clog2(PORT_NUM),
  localparam int VC_SIZE = $clog2(VC_NUM)
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]                    request_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0]     out_port_i,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]                    vc_grant_o,
  output logic [PORT_NUM-1:0][PORT_SIZE-1:0]                 sel_o,
  output logic [PORT_NUM-1:0]                                valid_o
);

  localparam logic [PORT_SIZE-1:0] PORT_LAST = PORT_SIZE'(PORT_NUM - 1);
  localparam logic [VC_SIZE-1:0]   VC_LAST   = VC_SIZE'(VC_NUM - 1);

  logic [PORT_NUM-1:0][VC_SIZE-1:0]   in_ptr_q, in_ptr_d;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] out_ptr_q, out_ptr_d;
  logic [PORT_NUM-1:0][VC_NUM-1:0]    grant_q, grant_d;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] sel_q, sel_d;
  logic [PORT_NUM-1:0]                valid_q, valid_d;

  logic [PORT_NUM-1:0]                cand_valid;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]   cand_vc;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] cand_port;

  // Stage 1: per input, first effective VC request at or after in_ptr.
  always_comb begin
    logic [VC_SIZE:0]   vsum;
    logic [VC_SIZE-1:0] vidx;
    cand_valid = '0;
    cand_vc    = '0;
    cand_port  = '0;
    vsum       = '0;
    vidx       = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int k = 0; k < VC_NUM; k++) begin
        vsum = {1'b0, in_ptr_q[p]} + (VC_SIZE + 1)'(k);
        if (vsum >= (VC_SIZE + 1)'(VC_NUM)) vsum = vsum - (VC_SIZE + 1)'(VC_NUM);
        vidx = vsum[VC_SIZE-1:0];
        if (!cand_valid[p] && request_i[p][vidx] && (out_port_i[p][vidx] <= PORT_LAST)) begin
          cand_valid[p] = 1'b1;
          cand_vc[p]    = vidx;
          cand_port[p]  = out_port_i[p][vidx];
        end
      end
    end
  end

  // Stage 2: per output, first candidate input at or after out_ptr; also next-state.
  always_comb begin
    logic [PORT_SIZE:0]   psum;
    logic [PORT_SIZE-1:0] pidx;
    logic [PORT_SIZE-1:0] win;
    logic                 found;
    grant_d   = '0;
    sel_d     = '0;
    valid_d   = '0;
    in_ptr_d  = in_ptr_q;
    out_ptr_d = out_ptr_q;
    psum      = '0;
    pidx      = '0;
    win       = '0;
    found     = 1'b0;
    for (int o = 0; o < PORT_NUM; o++) begin
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < PORT_NUM; k++) begin
        psum = {1'b0, out_ptr_q[o]} + (PORT_SIZE + 1)'(k);
        if (psum >= (PORT_SIZE + 1)'(PORT_NUM)) psum = psum - (PORT_SIZE + 1)'(PORT_NUM);
        pidx = psum[PORT_SIZE-1:0];
        if (!found && cand_valid[pidx] && (cand_port[pidx] == PORT_SIZE'(o))) begin
          found = 1'b1;
          win   = pidx;
        end
      end
      if (found) begin
        valid_d[o]                = 1'b1;
        sel_d[o]                  = win;
        grant_d[win][cand_vc[win]] = 1'b1;
        out_ptr_d[o]              = (win == PORT_LAST) ? '0 : win + 1'b1;
        in_ptr_d[win]             = (cand_vc[win] == VC_LAST) ? '0 : cand_vc[win] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ptr_q  <= '0;
      out_ptr_q <= '0;
      grant_q   <= '0;
      sel_q     <= '0;
      valid_q   <= '0;
    end else begin
      in_ptr_q  <= in_ptr_d;
      out_ptr_q <= out_ptr_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
    end
  end

  assign vc_grant_o = grant_q;
  assign sel_o      = sel_q;
  assign valid_o    = valid_q;

endmodule

// File: tb/tb_switch_allocator.sv
// tb/tb_switch_allocator.sv - bench for switch_allocator
// Directed vector table, async reset sequence, and randomized run against a reference model.
module tb_switch_allocator;

  localparam int P  = 5;
  localparam int V  = 2;
  localparam int PS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [P-1:0][V-1:0]         req;
  logic [P-1:0][V-1:0][PS-1:0] op;
  logic [P-1:0][V-1:0]         grant;
  logic [P-1:0][PS-1:0]        sel;
  logic [P-1:0]                valid;

  int checks = 0;
  int errors = 0;

  switch_allocator #(.PORT_NUM(P), .VC_NUM(V)) dut (
    .clk       (clk),
    .rst       (rst),
    .request_i (req),
    .out_port_i(op),
    .vc_grant_o(grant),
    .sel_o     (sel),
    .valid_o   (valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                          rs;
    logic [P-1:0][V-1:0]         req;
    logic [P-1:0][V-1:0][PS-1:0] op;
    logic [P-1:0][V-1:0]         g;
    logic [P-1:0][PS-1:0]        s;
    logic [P-1:0]                v;
  } vec_t;

  vec_t tbl[$];

  logic [P-1:0][V-1:0]  m_grant;
  logic [P-1:0][PS-1:0] m_sel;
  logic [P-1:0]         m_valid;
  int m_in[P];
  int m_out[P];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t nv(input bit rs);
    vec_t t;
    t.rs = rs; t.req = '0; t.op = '0; t.g = '0; t.s = '0; t.v = '0;
    return t;
  endfunction

  task automatic model_reset();
    m_grant = '0; m_sel = '0; m_valid = '0;
    for (int i = 0; i < P; i++) begin m_in[i] = 0; m_out[i] = 0; end
  endtask

  // Reference: each input offers the first usable VC in rotating order; each output
  // takes the first offering input in rotating order; winners advance past themselves.
  task automatic model_step();
    int cand[P];
    int winner[P];
    for (int p = 0; p < P; p++) begin
      cand[p] = -1;
      for (int k = 0; k < V; k++) begin
        int v = (m_in[p] + k) % V;
        if (cand[p] < 0 && req[p][v] && int'(op[p][v]) < P) cand[p] = v;
      end
    end
    m_grant = '0; m_sel = '0; m_valid = '0;
    for (int o = 0; o < P; o++) begin
      winner[o] = -1;
      for (int k = 0; k < P; k++) begin
        int i = (m_out[o] + k) % P;
        if (winner[o] < 0 && cand[i] >= 0 && int'(op[i][cand[i]]) == o) winner[o] = i;
      end
    end
    for (int o = 0; o < P; o++) begin
      if (winner[o] >= 0) begin
        int w = winner[o];
        m_valid[o] = 1'b1;
        m_sel[o] = PS'(w);
        m_grant[w][cand[w]] = 1'b1;
        m_out[o] = (w + 1) % P;
        m_in[w] = (cand[w] + 1) % V;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vec_t t;
    int seq[4];
    seq = '{0, 1, 3, 0};

    t = nv(1); t.req[2][1] = 1'b1; t.op[2][1] = 3'd4;
    t.g[2] = 2'b10; t.s[4] = 3'd2; t.v = 5'b10000; tbl.push_back(t);
    t = nv(0); tbl.push_back(t);

    for (int j = 0; j < 4; j++) begin
      t = nv(j == 0);
      t.req[0][0] = 1'b1; t.req[1][0] = 1'b1; t.req[3][0] = 1'b1;
      t.op[0][0] = 3'd2; t.op[1][0] = 3'd2; t.op[3][0] = 3'd2;
      t.g[seq[j]][0] = 1'b1; t.s[2] = PS'(seq[j]); t.v = 5'b00100;
      tbl.push_back(t);
    end

    for (int j = 0; j < 3; j++) begin
      t = nv(j == 0);
      t.req[1] = 2'b11; t.op[1][0] = 3'd0; t.op[1][1] = 3'd3;
      if (j % 2 == 0) begin t.g[1] = 2'b01; t.s[0] = 3'd1; t.v = 5'b00001; end
      else            begin t.g[1] = 2'b10; t.s[3] = 3'd1; t.v = 5'b01000; end
      tbl.push_back(t);
    end

    for (int j = 0; j < 3; j++) begin
      t = nv(j == 0);
      t.req[0] = 2'b11; t.op[0][0] = 3'd1; t.op[0][1] = 3'd2;
      t.req[3][0] = 1'b1; t.op[3][0] = 3'd1;
      if (j == 1) begin
        t.g[0] = 2'b10; t.g[3] = 2'b01; t.s[1] = 3'd3; t.s[2] = 3'd0; t.v = 5'b00110;
      end else begin
        t.g[0] = 2'b01; t.s[1] = 3'd0; t.v = 5'b00010;
      end
      tbl.push_back(t);
    end

    for (int j = 0; j < 4; j++) begin
      t = nv(j == 0);
      t.req[4] = 2'b11; t.op[4][1] = 3'd7; t.op[4][0] = 3'd0;
      t.g[4] = 2'b01; t.s[0] = 3'd4; t.v = 5'b00001;
      tbl.push_back(t);
    end

    req = '0; op = '0;
    #12;
    chk("reset_grant", 64'(grant), 64'd0);
    chk("reset_sel",   64'(sel),   64'd0);
    chk("reset_valid", 64'(valid), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rs) do_reset();
      req = tbl[i].req;
      op  = tbl[i].op;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_grant", i), 64'(grant), 64'(tbl[i].g));
      chk($sformatf("vec%0d_sel",   i), 64'(sel),   64'(tbl[i].s));
      chk($sformatf("vec%0d_valid", i), 64'(valid), 64'(tbl[i].v));
    end

    // Asynchronous reset in the middle of a cycle with requests still active.
    do_reset();
    req = '0; op = '0;
    req[0][0] = 1'b1; req[1][0] = 1'b1; op[0][0] = 3'd2; op[1][0] = 3'd2;
    @(posedge clk); #1;
    chk("pre_rst_valid", 64'(valid), 64'(5'b00100));
    #3 rst = 1'b1;
    #1;
    chk("midrst_grant", 64'(grant), 64'd0);
    chk("midrst_sel",   64'(sel),   64'd0);
    chk("midrst_valid", 64'(valid), 64'd0);
    req = '0;
    @(negedge clk); rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      chk($sformatf("idle%0d_valid", j), 64'(valid), 64'd0);
    end

    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        do_reset();
        model_reset();
        #1 chk("rand_rst_valid", 64'(valid), 64'd0);
      end
      for (int p = 0; p < P; p++)
        for (int v = 0; v < V; v++) begin
          req[p][v] = ($urandom_range(0, 2) != 0);
          op[p][v]  = PS'($urandom_range(0, 5));
        end
      @(posedge clk);
      model_step();
      #1;
      chk("rand_grant", 64'(grant), 64'(m_grant));
      chk("rand_sel",   64'(sel),   64'(m_sel));
      chk("rand_valid", 64'(valid), 64'(m_valid));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
